ddr4_v2_2_24_tg_rd_checker: RTL and testbench

Multiport read-data checker for the DDR4 traffic generator, directly downstream of the TG multiport FIFO that holds expected read data. Each cycle it accepts up to NUM_PORT returned read beats, pops the same number of expected entries from the FIFO, and compares them lane by lane through a two-stage pipeline. It reports per-lane mismatches, saturating error and compare counters, sticky protocol/underflow flags, and a snapshot of the first failing beat.

---
 rtl/ddr4_v2_2_24_tg_rd_checker.sv | 198 +++++++++++++++++++
 tb/tb_ddr4_v2_2_24_tg_rd_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_v2_2_24_tg_rd_checker.sv
// Multiport read-data checker for the DDR4 traffic generator.
// Accepts up to NUM_PORT returned beats per cycle, pops the matching number of
// expected entries from the upstream FIFO, and compares them lane by lane in a
// two-stage pipeline. It reports per-lane mismatch pulses, saturating counters,
// sticky protocol/underflow flags and a snapshot of the first failing beat.
module ddr4_v2_2_24_tg_rd_checker #(
  parameter int TCQ          = 100,
  parameter int WIDTH        = 576,
  parameter int NUM_PORT     = 4,
  parameter int LOG2NUM_PORT = 2,
  parameter int LOG2DEPTH    = 2,
  parameter int ERR_CNT_W    = 16,
  parameter int CMP_CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORT-1:0]          rd_valid,
  input  logic [NUM_PORT*WIDTH-1:0]    rd_data,
  input  logic [NUM_PORT*WIDTH-1:0]    exp_dout,
  input  logic [LOG2DEPTH:0]           exp_cnt,
  output logic [NUM_PORT-1:0]          exp_rden,
  input  logic                         clr_err,
  output logic [NUM_PORT-1:0]          err_lane,
  output logic                         err_sticky,
  output logic [ERR_CNT_W-1:0]         err_cnt,
  output logic [CMP_CNT_W-1:0]         cmp_cnt,
  output logic                         underflow,
  output logic                         proto_err,
  output logic                         first_err_vld,
  output logic [LOG2NUM_PORT-1:0]      first_err_lane,
  output logic [WIDTH-1:0]             first_err_exp,
  output logic [WIDTH-1:0]             first_err_act
);

  // Popcount width (holds 0..NUM_PORT) and a common width for comparing it
  // against the FIFO occupancy.
  localparam int PC_W      = LOG2NUM_PORT + 1;
  localparam int EC_W      = LOG2DEPTH + 1;
  localparam int CMP_W     = (PC_W > EC_W) ? PC_W : EC_W;
  localparam int ERR_SUM_W = ((ERR_CNT_W > PC_W) ? ERR_CNT_W : PC_W) + 1;
  localparam int CMP_SUM_W = ((CMP_CNT_W > PC_W) ? CMP_CNT_W : PC_W) + 1;

  // TCQ only shapes clock-to-q in behavioural models; the synthesized
  // registers carry no delay, so it just has to be a sane value here.
  if (TCQ < 0) begin : g_tcq_negative
  end

  // ---------------------------------------------------------------------------
  // Accept decision (combinational, same cycle as the FIFO pop)
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]     w_in_pop;
  logic                w_nonzero;
  logic                w_thermo;
  logic                w_proto;
  logic                w_under;
  logic                w_accept;

  // Count how many beats arrived this cycle.
  always_comb begin
    w_in_pop = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      w_in_pop = w_in_pop + PC_W'(rd_valid[i]);
    end
  end

  // A thermometer mask from lane 0 plus one is a power of two, so the AND is 0.
  assign w_nonzero = |rd_valid;
  assign w_thermo  = ((rd_valid & (rd_valid + NUM_PORT'(1))) == '0);
  assign w_proto   = w_nonzero & ~w_thermo;
  assign w_under   = w_nonzero & w_thermo & (CMP_W'(w_in_pop) > CMP_W'(exp_cnt));
  assign w_accept  = w_nonzero & w_thermo & ~w_under;
  assign exp_rden  = w_accept ? rd_valid : '0;

  // ---------------------------------------------------------------------------
  // Stage 1: capture accepted lanes
  // ---------------------------------------------------------------------------
  logic [NUM_PORT-1:0] r_s1_vld;
  logic [WIDTH-1:0]    r_s1_act [NUM_PORT];
  logic [WIDTH-1:0]    r_s1_exp [NUM_PORT];
  logic [NUM_PORT-1:0] w_mis;

  // Stage-1 valid mask; only this needs clearing to drop in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s1_vld <= '0;
    else        r_s1_vld <= exp_rden;
  end

  for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_lane
    // Per-lane data capture; unaccepted lanes keep stale data masked by vld.
    always_ff @(posedge clk) begin
      if (exp_rden[gi]) begin
        r_s1_act[gi] <= rd_data[gi*WIDTH +: WIDTH];
        r_s1_exp[gi] <= exp_dout[gi*WIDTH +: WIDTH];
      end
    end
    assign w_mis[gi] = r_s1_vld[gi] & (r_s1_act[gi] != r_s1_exp[gi]);
  end

  // ---------------------------------------------------------------------------
  // Stage 2: counters, sticky flags and first-error snapshot
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]         w_cmp_inc;
  logic [PC_W-1:0]         w_err_inc;
  logic [LOG2NUM_PORT-1:0] w_first_idx;
  logic [ERR_SUM_W-1:0]    w_err_sum;
  logic [CMP_SUM_W-1:0]    w_cmp_sum;
  logic [ERR_CNT_W-1:0]    w_err_cnt_next;
  logic [CMP_CNT_W-1:0]    w_cmp_cnt_next;
  logic                    w_first_base;

  logic [NUM_PORT-1:0]     r_err_lane;
  logic                    r_err_sticky;
  logic [ERR_CNT_W-1:0]    r_err_cnt;
  logic [CMP_CNT_W-1:0]    r_cmp_cnt;
  logic                    r_underflow;
  logic                    r_proto_err;
  logic                    r_first_vld;
  logic [LOG2NUM_PORT-1:0] r_first_lane;
  logic [WIDTH-1:0]        r_first_exp;
  logic [WIDTH-1:0]        r_first_act;

  // Lane counts for this stage-2 result and the lowest mismatching lane.
  always_comb begin
    w_cmp_inc   = '0;
    w_err_inc   = '0;
    w_first_idx = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      w_cmp_inc = w_cmp_inc + PC_W'(r_s1_vld[i]);
      w_err_inc = w_err_inc + PC_W'(w_mis[i]);
    end
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (w_mis[i]) w_first_idx = LOG2NUM_PORT'(i);
    end
  end

  // Saturating counter updates; clr_err restarts from zero but keeps the new increment.
  always_comb begin
    w_err_sum = ERR_SUM_W'(clr_err ? '0 : r_err_cnt) + ERR_SUM_W'(w_err_inc);
    w_cmp_sum = CMP_SUM_W'(clr_err ? '0 : r_cmp_cnt) + CMP_SUM_W'(w_cmp_inc);
    if (w_err_sum > ERR_SUM_W'({ERR_CNT_W{1'b1}})) w_err_cnt_next = '1;
    else                                           w_err_cnt_next = w_err_sum[ERR_CNT_W-1:0];
    if (w_cmp_sum > CMP_SUM_W'({CMP_CNT_W{1'b1}})) w_cmp_cnt_next = '1;
    else                                           w_cmp_cnt_next = w_cmp_sum[CMP_CNT_W-1:0];
  end

  assign w_first_base = r_first_vld & ~clr_err;

  // Result registers; a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_lane   <= '0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_cmp_cnt    <= '0;
      r_underflow  <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_err_lane   <= w_mis;
      r_err_sticky <= (r_err_sticky & ~clr_err) | (|w_mis);
      r_err_cnt    <= w_err_cnt_next;
      r_cmp_cnt    <= w_cmp_cnt_next;
      r_underflow  <= (r_underflow & ~clr_err) | w_under;
      r_proto_err  <= (r_proto_err & ~clr_err) | w_proto;
    end
  end

  // First-error snapshot: captured once, re-armed by clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_vld  <= 1'b0;
      r_first_lane <= '0;
      r_first_exp  <= '0;
      r_first_act  <= '0;
    end else if (!w_first_base && (|w_mis)) begin
      r_first_vld  <= 1'b1;
      r_first_lane <= w_first_idx;
      r_first_exp  <= r_s1_exp[w_first_idx];
      r_first_act  <= r_s1_act[w_first_idx];
    end else if (clr_err) begin
      r_first_vld  <= 1'b0;
      r_first_lane <= '0;
      r_first_exp  <= '0;
      r_first_act  <= '0;
    end
  end

  assign err_lane       = r_err_lane;
  assign err_sticky     = r_err_sticky;
  assign err_cnt        = r_err_cnt;
  assign cmp_cnt        = r_cmp_cnt;
  assign underflow      = r_underflow;
  assign proto_err      = r_proto_err;
  assign first_err_vld  = r_first_vld;
  assign first_err_lane = r_first_lane;
  assign first_err_exp  = r_first_exp;
  assign first_err_act  = r_first_act;

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_rd_checker.sv
// Directed bench for the multiport read checker. A small queue models the
// expected-data FIFO; a second instance with a 2-bit error counter covers
// saturation.
module tb_ddr4_v2_2_24_tg_rd_checker;
  localparam int W    = 576;
  localparam int NP   = 4;
  localparam int L2NP = 2;
  localparam int L2D  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     rd_valid;
  logic [NP*W-1:0]   rd_data;
  logic [NP*W-1:0]   exp_dout;
  logic [L2D:0]      exp_cnt;
  logic [NP-1:0]     exp_rden;
  logic              clr_err;
  logic [NP-1:0]     err_lane;
  logic              err_sticky;
  logic [15:0]       err_cnt;
  logic [31:0]       cmp_cnt;
  logic              underflow;
  logic              proto_err;
  logic              first_err_vld;
  logic [L2NP-1:0]   first_err_lane;
  logic [W-1:0]      first_err_exp;
  logic [W-1:0]      first_err_act;

  logic [NP-1:0]     s_exp_rden;
  logic [NP-1:0]     s_err_lane;
  logic              s_err_sticky;
  logic [1:0]        s_err_cnt;
  logic [31:0]       s_cmp_cnt;
  logic              s_underflow;
  logic              s_proto_err;
  logic              s_first_err_vld;
  logic [L2NP-1:0]   s_first_err_lane;
  logic [W-1:0]      s_first_err_exp;
  logic [W-1:0]      s_first_err_act;

  int tests = 0;
  int fails = 0;
  logic [W-1:0]  fifo_q[$];
  logic [NP-1:0] pend;

  always #5 clk = ~clk;

  ddr4_v2_2_24_tg_rd_checker #(
    .WIDTH(W), .NUM_PORT(NP), .LOG2NUM_PORT(L2NP), .LOG2DEPTH(L2D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_data(rd_data),
    .exp_dout(exp_dout), .exp_cnt(exp_cnt), .exp_rden(exp_rden),
    .clr_err(clr_err), .err_lane(err_lane), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .cmp_cnt(cmp_cnt), .underflow(underflow),
    .proto_err(proto_err), .first_err_vld(first_err_vld),
    .first_err_lane(first_err_lane), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act)
  );

  ddr4_v2_2_24_tg_rd_checker #(
    .WIDTH(W), .NUM_PORT(NP), .LOG2NUM_PORT(L2NP), .LOG2DEPTH(L2D), .ERR_CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_data(rd_data),
    .exp_dout(exp_dout), .exp_cnt(exp_cnt), .exp_rden(s_exp_rden),
    .clr_err(clr_err), .err_lane(s_err_lane), .err_sticky(s_err_sticky),
    .err_cnt(s_err_cnt), .cmp_cnt(s_cmp_cnt), .underflow(s_underflow),
    .proto_err(s_proto_err), .first_err_vld(s_first_err_vld),
    .first_err_lane(s_first_err_lane), .first_err_exp(s_first_err_exp),
    .first_err_act(s_first_err_act)
  );

  function automatic logic [W-1:0] word(input int k);
    logic [31:0] s;
    s = 32'hA500_0000 | 32'(k);
    return {18{s}};
  endfunction

  function automatic logic [NP*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present the FIFO head to the checker as the real FIFO would.
  task automatic refresh();
    exp_cnt = (fifo_q.size() > 15) ? 4'd15 : 4'(fifo_q.size());
    for (int i = 0; i < NP; i++)
      exp_dout[i*W +: W] = (i < fifo_q.size()) ? fifo_q[i] : '0;
  endtask

  task automatic begin_cycle(input logic [NP-1:0] v, input logic [NP*W-1:0] d, input logic clr);
    @(negedge clk);
    refresh();
    rd_valid = v;
    rd_data  = d;
    clr_err  = clr;
    #1;
    pend = exp_rden;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    for (int i = 0; i < NP; i++)
      if (pend[i] && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
  endtask

  task automatic idle();
    begin_cycle('0, '0, 1'b0);
    end_cycle();
  endtask

  initial begin
    rst_n = 1'b0; rd_valid = '0; rd_data = '0; exp_dout = '0; exp_cnt = '0; clr_err = 1'b0;
    pend = '0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] step reset");
    chk("rst_err_cnt", W'(err_cnt), '0);
    chk("rst_cmp_cnt", W'(cmp_cnt), '0);
    chk("rst_sticky", W'(err_sticky), '0);
    chk("rst_first_vld", W'(first_err_vld), '0);
    chk("rst_rden", W'(exp_rden), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream: 8 matching beats over two full-width cycles.
    $display("[TB] step clean stream");
    for (int k = 0; k < 8; k++) fifo_q.push_back(word(k));
    begin_cycle(4'b1111, pack4(word(0), word(1), word(2), word(3)), 1'b0);
    chk("clean_rden0", W'(exp_rden), W'(4'b1111));
    end_cycle();
    begin_cycle(4'b1111, pack4(word(4), word(5), word(6), word(7)), 1'b0);
    chk("clean_rden1", W'(exp_rden), W'(4'b1111));
    chk("clean_expcnt", W'(exp_cnt), W'(4));
    end_cycle();
    chk("clean_cmp4", W'(cmp_cnt), W'(4));
    idle();
    chk("clean_cmp8", W'(cmp_cnt), W'(8));
    chk("clean_err_cnt", W'(err_cnt), '0);
    chk("clean_sticky", W'(err_sticky), '0);

    // Mismatch on lane 1, bit 0.
    $display("[TB] step mismatch lane1");
    fifo_q.push_back(word(10));
    fifo_q.push_back(word(11));
    begin_cycle(4'b0011, pack4(word(10), word(11) ^ W'(1), '0, '0), 1'b0);
    chk("mis_rden", W'(exp_rden), W'(4'b0011));
    end_cycle();
    chk("mis_lane_early", W'(err_lane), '0);
    idle();
    chk("mis_err_lane", W'(err_lane), W'(4'b0010));
    chk("mis_err_cnt", W'(err_cnt), W'(1));
    chk("mis_cmp_cnt", W'(cmp_cnt), W'(10));
    chk("mis_sticky", W'(err_sticky), W'(1));
    chk("mis_first_vld", W'(first_err_vld), W'(1));
    chk("mis_first_lane", W'(first_err_lane), W'(1));
    chk("mis_first_exp", first_err_exp, word(11));
    chk("mis_first_act", first_err_act, word(11) ^ W'(1));
    idle();
    chk("mis_lane_pulse", W'(err_lane), '0);
    chk("mis_sticky_hold", W'(err_sticky), W'(1));

    // Underflow: three beats but only two expected entries.
    $display("[TB] step underflow");
    fifo_q.push_back(word(20));
    fifo_q.push_back(word(21));
    begin_cycle(4'b0111, pack4(word(20), word(21), word(22), '0), 1'b0);
    chk("uf_rden", W'(exp_rden), '0);
    end_cycle();
    chk("uf_flag", W'(underflow), W'(1));
    chk("uf_proto", W'(proto_err), '0);
    chk("uf_fifo_cnt", W'(fifo_q.size()), W'(2));
    idle();
    idle();
    chk("uf_cmp_cnt", W'(cmp_cnt), W'(10));

    // Protocol error: non-thermometer mask.
    $display("[TB] step protocol error");
    begin_cycle(4'b0101, pack4(word(20), '0, word(21), '0), 1'b0);
    chk("pe_rden", W'(exp_rden), '0);
    end_cycle();
    chk("pe_flag", W'(proto_err), W'(1));
    chk("pe_fifo_cnt", W'(fifo_q.size()), W'(2));

    // Two-lane mismatch whose stage-2 result lands in the clr_err cycle.
    $display("[TB] step clear with coincident mismatch");
    begin_cycle(4'b0011, pack4(word(20) ^ W'(1), word(21) ^ W'(2), '0, '0), 1'b0);
    chk("clr_rden", W'(exp_rden), W'(4'b0011));
    end_cycle();
    begin_cycle('0, '0, 1'b1);
    end_cycle();
    chk("clr_err_cnt", W'(err_cnt), W'(2));
    chk("clr_proto", W'(proto_err), '0);
    chk("clr_underflow", W'(underflow), '0);
    chk("clr_cmp_cnt", W'(cmp_cnt), W'(2));
    chk("clr_sticky", W'(err_sticky), W'(1));
    chk("clr_err_lane", W'(err_lane), W'(4'b0011));
    chk("clr_first_lane", W'(first_err_lane), '0);
    chk("clr_first_exp", first_err_exp, word(20));
    chk("clr_first_act", first_err_act, word(20) ^ W'(1));
    idle();

    // Asynchronous reset with four lanes in flight.
    $display("[TB] step mid-stream reset");
    for (int k = 30; k < 34; k++) fifo_q.push_back(word(k));
    begin_cycle(4'b1111, pack4(word(30), word(31), word(32), word(33)), 1'b0);
    end_cycle();
    @(negedge clk);
    rd_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("ar_err_cnt", W'(err_cnt), '0);
    chk("ar_cmp_cnt", W'(cmp_cnt), '0);
    chk("ar_sticky", W'(err_sticky), '0);
    chk("ar_first_vld", W'(first_err_vld), '0);
    chk("ar_first_exp", first_err_exp, '0);
    chk("ar_err_lane", W'(err_lane), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    begin_cycle('0, '0, 1'b0);
    chk("ar_rden_idle", W'(exp_rden), '0);
    end_cycle();
    chk("ar_cmp_after", W'(cmp_cnt), '0);
    chk("ar_fifo_empty", W'(fifo_q.size()), '0);

    // Saturation: five mismatching lanes against a 2-bit error counter.
    $display("[TB] step saturation");
    for (int k = 40; k < 44; k++) fifo_q.push_back(word(k));
    begin_cycle(4'b1111, pack4(word(40) ^ W'(1), word(41) ^ W'(1), word(42) ^ W'(1), word(43) ^ W'(1)), 1'b0);
    end_cycle();
    idle();
    chk("sat_main_err4", W'(err_cnt), W'(4));
    chk("sat_err_cnt4", W'(s_err_cnt), W'(3));
    fifo_q.push_back(word(44));
    begin_cycle(4'b0001, pack4(word(44) ^ W'(1), '0, '0, '0), 1'b0);
    end_cycle();
    idle();
    chk("sat_main_err5", W'(err_cnt), W'(5));
    chk("sat_err_cnt5", W'(s_err_cnt), W'(3));
    chk("sat_cmp_cnt", W'(s_cmp_cnt), W'(5));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
